// File: rtl/intr_sched_pkg.sv
// Shared types and constants for the interrupt scheduler.
// Also defines the wrap-around index helper used by the round-robin pointer.
package intr_sched_pkg;

  localparam int MAX_SRC = 4;
  localparam int CODE_W  = 2;
  localparam int HOLD_W  = 16;
  localparam int GAP_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  typedef logic [CODE_W-1:0] code_t;

  // Index following idx in a ring of n sources.
  function automatic code_t next_code(input code_t idx, input int n);
    return (int'(idx) == n - 1) ? '0 : code_t'(idx + 1'b1);
  endfunction

endpackage

// File: rtl/intr_sched_if.sv
// Event/handshake bundle between the event sources, software and the scheduler.
// The slave modport is the scheduler side; master is the source/software side.
interface intr_sched_if #(
  parameter int SRC_NUM = 4
);
  import intr_sched_pkg::*;

  logic [SRC_NUM-1:0] src_evt;
  logic [SRC_NUM-1:0] src_mask;
  logic               ack;
  logic               err_clr;
  code_t              intr_code;
  logic               intr_valid;
  logic [SRC_NUM-1:0] pending;
  logic [SRC_NUM-1:0] overflow;
  logic               timeout_err;

  modport master (
    output src_evt, src_mask, ack, err_clr,
    input  intr_code, intr_valid, pending, overflow, timeout_err
  );

  modport slave (
    input  src_evt, src_mask, ack, err_clr,
    output intr_code, intr_valid, pending, overflow, timeout_err
  );

endinterface

// File: rtl/intr_sched_rr_arbiter.sv
// Combinational round-robin picker: first set bit of eligible at or above ptr, with wrap.
// Kept standalone so other owners (e.g. the LED arbiter) can reuse it.
module rr_arbiter
  import intr_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] eligible_i,
  input  code_t        ptr_i,
  output code_t        grant_o,
  output logic         any_grant_o
);

  code_t idx;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    grant_o     = ptr_i;
    any_grant_o = 1'b0;
    idx         = '0;
    for (int off = 0; off < N; off++) begin
      idx = code_t'((int'(ptr_i) + off) % N);
      if (!any_grant_o && eligible_i[idx]) begin
        grant_o     = idx;
        any_grant_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_sched.sv
// Interrupt scheduler: edge-detects event sources into pending flags and presents them
// one at a time on a 2-bit code + valid, held until ack or timeout, then an idle gap.
module intr_sched
  import intr_sched_pkg::*;
#(
  parameter int               SRC_NUM      = 4,
  parameter logic [HOLD_W-1:0] HOLD_TIMEOUT = 16'd12500,
  parameter logic [GAP_W-1:0]  GAP_CYC      = 8'd4
) (
  input  logic          clk,
  input  logic          rst_n,
  intr_sched_if.slave   bus
);

  state_e              state_q, state_d;
  logic [SRC_NUM-1:0]  evt_prev_q;
  logic [SRC_NUM-1:0]  pending_q, pending_d;
  logic [SRC_NUM-1:0]  overflow_q, overflow_d;
  logic                terr_q, terr_d;
  code_t               code_q, code_d;
  code_t               ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [GAP_W-1:0]    gap_q, gap_d;

  logic [SRC_NUM-1:0]  evt_rise;
  logic [SRC_NUM-1:0]  eligible;
  logic [SRC_NUM-1:0]  clr_vec;
  code_t               grant;
  logic                any_grant;
  logic                ack_hit;
  logic                hold_expired;
  logic                gap_done;
  logic                req_end;

  assign evt_rise     = bus.src_evt & ~evt_prev_q;
  assign eligible     = pending_q & ~bus.src_mask;
  assign ack_hit      = (state_q == ST_ASSERT) && bus.ack;
  assign hold_expired = (state_q == ST_ASSERT) && (hold_q == HOLD_TIMEOUT - HOLD_W'(1));
  assign gap_done     = (gap_q == GAP_CYC - GAP_W'(1));
  assign req_end      = ack_hit || hold_expired;

  rr_arbiter #(
    .N (SRC_NUM)
  ) u_rr_arbiter (
    .eligible_i  (eligible),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .any_grant_o (any_grant)
  );

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      evt_prev_q <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
      terr_q     <= 1'b0;
      code_q     <= '0;
      ptr_q      <= '0;
      hold_q     <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      evt_prev_q <= bus.src_evt;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      terr_q     <= terr_d;
      code_q     <= code_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (any_grant) state_d = ST_ASSERT;
      ST_ASSERT: if (req_end)   state_d = ST_GAP;
      ST_GAP:    if (gap_done)  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Grant, counters and pointer
  always_comb begin
    code_d = code_q;
    ptr_d  = ptr_q;
    hold_d = hold_q;
    gap_d  = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_grant) begin
          code_d = grant;
          hold_d = '0;
        end
      end
      ST_ASSERT: begin
        hold_d = hold_q + HOLD_W'(1);
        // A timed-out source still rotates the pointer so it cannot starve the rest.
        if (req_end) begin
          ptr_d = next_code(code_q, SRC_NUM);
          gap_d = '0;
        end
      end
      ST_GAP: gap_d = gap_q + GAP_W'(1);
      default: begin
        code_d = code_q;
      end
    endcase
  end

  // Pending and sticky error flags; a new edge beats a same-cycle clear.
  always_comb begin
    clr_vec = '0;
    if (ack_hit) clr_vec[code_q] = 1'b1;
    pending_d  = (pending_q & ~clr_vec) | evt_rise;
    overflow_d = (bus.err_clr ? '0 : overflow_q) | (evt_rise & pending_q & ~clr_vec);
    terr_d     = (bus.err_clr ? 1'b0 : terr_q) | (hold_expired && !bus.ack);
  end

  assign bus.intr_code   = code_q;
  assign bus.intr_valid  = (state_q == ST_ASSERT);
  assign bus.pending     = pending_q;
  assign bus.overflow    = overflow_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_intr_sched.sv
// Scoreboard bench for intr_sched: a timestamp-based reference model predicts each
// presented request (code and start cycle); a monitor pops and compares on valid rising.
module tb_intr_sched;
  import intr_sched_pkg::*;

  localparam int N    = 4;
  localparam int HT_I = 16;
  localparam int GC_I = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  intr_sched_if #(.SRC_NUM(N)) bus ();

  intr_sched #(
    .SRC_NUM      (N),
    .HOLD_TIMEOUT (16'(HT_I)),
    .GAP_CYC      (8'(GC_I))
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int code;
    int at;
  } req_t;
  req_t exp_q[$];

  // Reference model: flags as vectors, the scheduler as "busy since / free from" times.
  logic [N-1:0] m_pend, m_ovf, m_prev;
  logic         m_terr, m_active;
  int           m_code, m_start, m_next_ok, m_ptr;

  logic [N-1:0] evt_l, mask_l;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic model_reset();
    m_pend = '0; m_ovf = '0; m_prev = '0; m_terr = 1'b0; m_active = 1'b0;
    m_code = 0; m_start = 0; m_next_ok = 0; m_ptr = 0;
    exp_q.delete();
  endtask

  function automatic int pick(input logic [N-1:0] elig, input int ptr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (elig[i]) return i;
    end
    return -1;
  endfunction

  // Effect of the coming clock edge c on the model, given the inputs applied for it.
  task automatic model_step(input logic [N-1:0] evt, input logic [N-1:0] mask,
                            input logic a, input logic ec);
    int c, g;
    logic [N-1:0] rise, clr;
    logic tset, fin;
    c = cyc + 1;
    rise = evt & ~m_prev;
    clr = '0; tset = 1'b0; fin = 1'b0;
    if (m_active) begin
      if (a) begin
        clr[m_code] = 1'b1; fin = 1'b1;
      end else if (c - m_start == HT_I) begin
        tset = 1'b1; fin = 1'b1;
      end
      if (fin) begin
        m_active = 1'b0;
        m_ptr = (m_code + 1) % N;
        m_next_ok = c + GC_I + 1;
      end
    end else if (c >= m_next_ok) begin
      g = pick(m_pend & ~mask, m_ptr);
      if (g >= 0) begin
        m_active = 1'b1; m_code = g; m_start = c;
        exp_q.push_back('{code: g, at: c});
      end
    end
    m_ovf  = (ec ? '0 : m_ovf) | (rise & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | rise;
    m_terr = (ec ? 1'b0 : m_terr) | tset;
    m_prev = evt;
  endtask

  // Called at a falling edge: compare outputs, drive inputs, advance the model.
  task automatic cycle(input logic [N-1:0] evt, input logic [N-1:0] mask,
                       input logic a, input logic ec);
    check("intr_valid", bus.intr_valid, m_active);
    check("intr_code", bus.intr_code, m_code);
    check("pending", bus.pending, m_pend);
    check("overflow", bus.overflow, m_ovf);
    check("timeout_err", bus.timeout_err, m_terr);
    bus.src_evt = evt; bus.src_mask = mask; bus.ack = a; bus.err_clr = ec;
    model_step(evt, mask, a, ec);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(evt_l, mask_l, 1'b0, 1'b0);
  endtask

  task automatic wait_active(input string name);
    int k;
    k = 0;
    while (!m_active && k < 200) begin
      cycle(evt_l, mask_l, 1'b0, 1'b0);
      k++;
    end
    if (!m_active) bound_fail(name);
  endtask

  task automatic serve(input int hold);
    wait_active("serve");
    if (m_active) begin
      idle(hold);
      cycle(evt_l, mask_l, 1'b1, 1'b0);
    end
  endtask

  // Monitor: one expected entry per request start.
  initial begin
    logic pv;
    req_t r;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.intr_valid && !pv) begin
        if (exp_q.size() == 0) begin
          check("unexpected_request", bus.intr_code, 32'hFFFF_FFFF);
        end else begin
          r = exp_q.pop_front();
          check("req_code", bus.intr_code, r.code);
          check("req_cycle", cyc, r.at);
        end
      end
      pv = bus.intr_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    evt_l = '0; mask_l = '0;
    bus.src_evt = '0; bus.src_mask = '0; bus.ack = 1'b0; bus.err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", bus.intr_valid, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_terr", bus.timeout_err, 0);
    check("rst_code", bus.intr_code, 0);
    rst_n = 1'b1;
    idle(100);

    // Single event on source 2, acked after a short hold.
    evt_l = 4'b0100; idle(1);
    serve(8);
    evt_l = '0; idle(12);

    // Round-robin order, then again from pointer 0, then from pointer 2.
    evt_l = 4'b1011; repeat (3) serve(2);
    evt_l = '0; idle(8);
    evt_l = 4'b1011; repeat (3) serve(1);
    evt_l = '0; idle(8);
    evt_l = 4'b0010; serve(1);
    evt_l = '0; idle(8);
    evt_l = 4'b1011; repeat (3) serve(1);
    evt_l = '0; idle(10);

    // Timeout on source 1, re-presentation, err_clr, then ack on the timeout edge.
    evt_l = 4'b0010; wait_active("timeout_start");
    k = 0;
    while (m_active && k < 40) begin idle(1); k++; end
    if (m_active) bound_fail("timeout_end");
    wait_active("timeout_repeat");
    cycle(evt_l, mask_l, 1'b0, 1'b1);
    idle(2);
    cycle(evt_l, mask_l, 1'b1, 1'b0);
    evt_l = '0; idle(8);
    evt_l = 4'b0010; wait_active("ack_at_timeout");
    idle(HT_I - 1);
    cycle(evt_l, mask_l, 1'b1, 1'b0);
    evt_l = '0; idle(10);

    // Overflow on source 0, set beating err_clr, and ack/rise collision.
    evt_l = 4'b0001; idle(1);
    evt_l = '0; idle(1);
    evt_l = 4'b0001; idle(1);
    evt_l = '0; idle(1);
    cycle(4'b0001, mask_l, 1'b0, 1'b1);
    evt_l = '0;
    wait_active("collision");
    idle(1);
    cycle(4'b0001, mask_l, 1'b1, 1'b0);
    evt_l = 4'b0001; idle(2);
    cycle(evt_l, mask_l, 1'b0, 1'b1);
    serve(2);
    evt_l = '0; idle(10);

    // Mask gates arbitration only.
    mask_l = 4'b0001; evt_l = 4'b0101; idle(1);
    serve(2);
    idle(20);
    mask_l = '0;
    serve(1);
    evt_l = '0; idle(10);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] ev, tg;
      logic a, ec;
      tg = '0;
      for (int b = 0; b < N; b++) tg[b] = ($urandom_range(0, 7) == 0);
      ev = evt_l ^ tg;
      evt_l = ev;
      if ($urandom_range(0, 99) == 0) mask_l = N'($urandom_range(0, 15));
      a  = m_active ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 15) == 0);
      ec = ($urandom_range(0, 63) == 0);
      cycle(evt_l, mask_l, a, ec);
    end
    evt_l = '0; mask_l = '0; idle(20);
    while (m_active) cycle(evt_l, mask_l, 1'b1, 1'b0);
    idle(20);

    // Reset in the middle of a request.
    evt_l = 4'b0001; wait_active("mid_reset");
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.intr_valid, 0);
    check("arst_pending", bus.pending, 0);
    check("arst_overflow", bus.overflow, 0);
    check("arst_terr", bus.timeout_err, 0);
    check("arst_code", bus.intr_code, 0);
    evt_l = '0;
    bus.src_evt = '0; bus.ack = 1'b0; bus.err_clr = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    evt_l = 4'b1000; idle(1);
    serve(1);
    evt_l = '0; idle(20);

    check("exp_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intr_sched.md
Name: intr_sched

Overview:
- Interrupt scheduler between on-chip event sources and the 2-bit interrupt PIO of the soft-CPU system.
- Edge-detects up to 4 events and latches them as pending.
- Round-robin arbitration presents one source at a time as a 2-bit code plus valid.
- Holds each request until software acks or a timeout expires, then enforces an idle gap.

Parameters:
- SRC_NUM, 4, number of event sources (max 4, one per 2-bit code).
- HOLD_TIMEOUT, 16'd12500, cycles intr_valid stays high without ack before abort (100 us at 125 MHz); must be ≥1.
- GAP_CYC, 8'd4, idle cycles forced after every ack or abort; must be ≥1.

Ports:
- clk  in  1  system clock, 125 MHz.
- rst_n  in  1  asynchronous active-low reset.
- src_evt  in  SRC_NUM  event levels, synchronous to clk; rising edge = event.
- src_mask  in  SRC_NUM  1 = source excluded from arbitration.
- ack  in  1  single-cycle software acknowledge.
- err_clr  in  1  single-cycle clear of the sticky error flags.
- intr_code  out  2  index of the granted source; drives the PIO.
- intr_valid  out  1  request active.
- pending  out  SRC_NUM  latched pending events.
- overflow  out  SRC_NUM  sticky: event lost because the source was already pending.
- timeout_err  out  1  sticky: a request was aborted by timeout.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, rr pointer 0, edge-detect history 0, counters 0.
- Edge detect: evt_prev <= src_evt; edge = src_evt & ~evt_prev. Masked sources still latch pending; the mask gates arbitration only.
- Pending set: at the edge where edge[i]=1.
- Pending clear: only on ack of the granted source.
- Set/clear collision: a clear and a new edge on the same index in the same cycle leaves pending[i]=1 and does not flag overflow.
- Overflow: edge[i] while pending[i]=1 and not being cleared sets overflow[i].
- err_clr clears overflow and timeout_err. A set in the same cycle as err_clr wins.
- States: IDLE, ASSERT, GAP.
- IDLE: if eligible = pending & ~src_mask is nonzero, then grant = first eligible index searching upward from the rr pointer with wrap. Register intr_code=grant and intr_valid=1, clear the hold counter, go to ASSERT.
- Latency: src_evt first sampled high at edge k → pending at k → intr_valid high after edge k+1.
- ASSERT, ack=1: clear pending[grant], intr_valid<=0, rr pointer <= grant+1 mod SRC_NUM, go to GAP.
- ASSERT, hold counter reaches HOLD_TIMEOUT-1 without ack: intr_valid<=0 and timeout_err<=1. pending[grant] is kept. The rr pointer advances as for ack, so a stuck source cannot starve the others. Go to GAP. intr_valid is high for exactly HOLD_TIMEOUT cycles.
- Ack on the same edge as the timeout: the ack wins and no error is flagged.
- ack outside ASSERT is ignored.
- Masking the granted source during ASSERT does not abort the request.
- GAP: intr_valid=0 for exactly GAP_CYC cycles, then IDLE.
- intr_code holds its last value whenever intr_valid=0.
- Reset asserted mid-request: immediate return to the reset state. Pending events are lost.

Decomposition:
- intr_sched_pkg:
  - state enum (IDLE/ASSERT/GAP);
  - hold counter width (16) and gap counter width (8) constants;
  - max-source constant (4).
- Sub-module rr_arbiter (combinational): inputs eligible and ptr; outputs grant index and any_grant. Reusable for the planned LED-owner arbiter.

Test Plan:
- Reset release, no events → all outputs 0 for 100 cycles.
- Single event: src_evt[2] rises at edge 10 → pending=4'b0100 at edge 10; intr_valid=1 and intr_code=2 after edge 11. ack at edge 20 → pending=0 and intr_valid=0 after edge 20; intr_valid stays 0 for 4 cycles.
- Round-robin: src_evt rises 4'b1011 at once → codes presented in order 0, 1, 3, each acked. Re-raise 4'b1011 with the pointer at 0 → order 0, 1, 3 again. With the pointer at 2 (after granting 1) → 3 is presented first.
- Timeout: HOLD_TIMEOUT=16, event on source 1, no ack → intr_valid high exactly 16 cycles, timeout_err=1, pending[1] stays 1. After GAP the request re-presents as code 1 when it is the only source. err_clr → timeout_err=0.
- Overflow and collision:
  - Second rise of src_evt[0] while pending[0]=1 → overflow[0]=1.
  - Rise coincident with the ack of source 0 → pending[0]=1, overflow unchanged, request re-issued after GAP.
- Mask and mid-run reset:
  - src_mask=4'b0001 with sources 0 and 2 pending → only code 2 is presented. Unmask → code 0 is presented.
  - rst_n low during ASSERT → all outputs 0 asynchronously.
